// File: rtl/sdram_pkg.sv
// Shared request payload, sequencer state encoding and default timing for the SDRAM port sequencer.
package sdram_pkg;
  localparam int unsigned SD_ADDR_W   = 24;
  localparam int unsigned SD_DATA_W   = 16;
  localparam int unsigned SD_DEPTH    = 4;
  localparam int unsigned SD_READ_LAT = 8;
  localparam int unsigned SD_CYCLE    = 10;
  localparam int unsigned SD_STROBE_W = 2;

  typedef struct packed {
    logic                 we;
    logic                 word;
    logic [SD_ADDR_W-1:0] addr;
    logic [SD_DATA_W-1:0] din;
  } sdram_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sdram_state_t;
endpackage

// File: rtl/sdram_req_fifo.sv
// Request queue in front of the sequencer: registered storage, head visible combinationally.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = SD_DEPTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  sdram_req_t push_data,
  input  logic       pop,
  output sdram_req_t head,
  output logic       full,
  output logic       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  sdram_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/sdram_port_sequencer.sv
// Queues client requests and replays them as paced rd/wr edge strobes on one SDRAM controller port.
module sdram_port_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH    = SD_DEPTH,
  parameter int unsigned READ_LAT = SD_READ_LAT,
  parameter int unsigned CYCLE    = SD_CYCLE,
  parameter int unsigned STROBE_W = SD_STROBE_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_word,
  input  logic [SD_ADDR_W-1:0] req_addr,
  input  logic [SD_DATA_W-1:0] req_din,
  output logic                 rsp_valid,
  output logic [SD_DATA_W-1:0] rsp_data,
  output logic                 busy,
  output logic [SD_ADDR_W-1:0] sd_addr,
  output logic [SD_DATA_W-1:0] sd_din,
  output logic                 sd_word,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic [SD_DATA_W-1:0] sd_dout
);
  localparam int unsigned PACE_W = $clog2(CYCLE);
  localparam int unsigned TMR_W  = $clog2(READ_LAT + 1);
  localparam int unsigned SCNT_W = $clog2(STROBE_W + 1);

  sdram_state_t      state;
  sdram_req_t        push_req;
  sdram_req_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_c;
  logic              wait_done_c;
  logic              cur_we;
  logic [PACE_W-1:0] pace_cnt;
  logic [TMR_W-1:0]  rd_timer;
  logic [SCNT_W-1:0] scnt;

  assign push_req  = '{we: req_we, word: req_word, addr: req_addr, din: req_din};
  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign pop_c     = (state == ST_IDLE) && !fifo_empty && (pace_cnt == '0);
  // Both counters expire on this edge: pacing window closed and any read response delivered.
  assign wait_done_c = (pace_cnt <= PACE_W'(1)) && (rd_timer <= TMR_W'(1));

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pace counter spans pop-to-pop, so back-to-back strobe rises land exactly CYCLE apart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sd_addr   <= '0;
      sd_din    <= '0;
      sd_word   <= 1'b0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      cur_we    <= 1'b0;
      pace_cnt  <= '0;
      rd_timer  <= '0;
      scnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (pace_cnt != '0) pace_cnt <= pace_cnt - PACE_W'(1);
      if (rd_timer != '0) rd_timer <= rd_timer - TMR_W'(1);
      if (rd_timer == TMR_W'(1)) begin
        rsp_valid <= 1'b1;
        rsp_data  <= sd_dout;
      end
      case (state)
        ST_IDLE: begin
          if (pop_c) begin
            sd_addr  <= head.addr;
            sd_din   <= head.din;
            sd_word  <= head.word;
            cur_we   <= head.we;
            pace_cnt <= PACE_W'(CYCLE - 1);
            scnt     <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (scnt == '0) begin
            sd_rd <= !cur_we;
            sd_wr <= cur_we;
            scnt  <= SCNT_W'(1);
            if (!cur_we) rd_timer <= TMR_W'(READ_LAT);
          end else if (scnt == SCNT_W'(STROBE_W)) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= wait_done_c ? ST_IDLE : ST_WAIT;
          end else begin
            scnt <= scnt + SCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (wait_done_c) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_sequencer.sv
// Directed scoreboard bench for sdram_port_sequencer with a small controller/memory model.
module tb_sdram_port_sequencer;
  localparam int READ_LAT = 8;
  localparam int CYCLE    = 10;
  localparam int STROBE_W = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_word = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_din = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic [23:0] sd_addr;
  logic [15:0] sd_din;
  logic        sd_word;
  logic        sd_rd;
  logic        sd_wr;
  logic [15:0] sd_dout = 16'hDEAD;

  always #5 clk = ~clk;

  sdram_port_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_word(req_word), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_word(sd_word), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_dout(sd_dout)
  );

  typedef struct {
    bit          we;
    bit          word;
    logic [23:0] addr;
    logic [15:0] din;
  } iss_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  iss_t        exp_iss[$];
  logic [15:0] exp_rsp[$];
  logic [7:0]  mem [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rd_b(input int a);
    return mem.exists(a) ? mem[a] : (8'(a) ^ 8'h5A);
  endfunction

  // Controller model plus scoreboard monitor, all sampled on the falling edge.
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  int          hi_cnt = 0, last_rise = 0, last_rd_rise = -100, rise_count = 0;
  int          burst_start = 0, dout_at = -100;
  bit          gap_exact = 1'b0;
  logic [23:0] last_rd_addr = '0;
  logic [15:0] dout_val = '0;

  always @(negedge clk) begin
    iss_t        e;
    int          a;
    logic [15:0] r;
    if (!reset_n) begin
      prev_rd = 1'b0; prev_wr = 1'b0; hi_cnt = 0; dout_at = -100; sd_dout = 16'hDEAD;
    end else begin
      chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 0);
      if ((sd_rd && !prev_rd) || (sd_wr && !prev_wr)) begin
        chk("issue_expected", 32'(exp_iss.size() != 0), 1);
        if (exp_iss.size() != 0) begin
          e = exp_iss.pop_front();
          chk("issue_we", 32'(sd_wr), 32'(e.we));
          chk("issue_addr", 32'(sd_addr), 32'(e.addr));
          chk("issue_word", 32'(sd_word), 32'(e.word));
          if (e.we) chk("issue_din", 32'(sd_din), 32'(e.din));
        end
        if (rise_count > burst_start) begin
          if (gap_exact) chk("pace_gap", 32'(cyc - last_rise), CYCLE);
          else chk("pace_min", 32'((cyc - last_rise) >= CYCLE), 1);
        end
        last_rise = cyc;
        rise_count++;
        a = int'({8'h00, sd_addr});
        if (sd_wr) begin
          if (sd_word) begin
            mem[a & ~1] = sd_din[7:0];
            mem[a | 1]  = sd_din[15:8];
          end else mem[a] = sd_din[7:0];
        end else begin
          last_rd_rise = cyc;
          last_rd_addr = sd_addr;
          dout_val = sd_word ? {rd_b(a | 1), rd_b(a & ~1)} : {rd_b(a), rd_b(a)};
          dout_at = cyc + READ_LAT - 1;
        end
      end
      if (!(sd_rd || sd_wr) && (prev_rd || prev_wr)) chk("strobe_width", 32'(hi_cnt), STROBE_W);
      hi_cnt = (sd_rd || sd_wr) ? hi_cnt + 1 : 0;
      prev_rd = sd_rd;
      prev_wr = sd_wr;
      // Read data is valid only across the edge READ_LAT cycles after the rd rise.
      if (cyc == dout_at) sd_dout = dout_val;
      else if (cyc == dout_at + 1) sd_dout = 16'hDEAD;
      if (rsp_valid) begin
        chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(r));
          chk("rsp_latency", 32'(cyc - last_rd_rise), READ_LAT);
          chk("rsp_addr_held", 32'(sd_addr), 32'(last_rd_addr));
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(sd_rd && sd_wr))
    else $error("FAIL rd_wr_overlap: rd and wr high together");

  // Entered and left on a falling edge; leaves req_valid low unless the next push follows.
  task automatic push(input bit we, input bit word, input logic [23:0] a, input logic [15:0] d,
                      input logic [15:0] exp, output int acc_cyc, output int waited);
    iss_t e;
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = a; req_din = d;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("push_ready", 32'(req_ready), 1);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 1'b0;
    e.we = we; e.word = word; e.addr = a; e.din = d;
    exp_iss.push_back(e);
    if (!we) exp_rsp.push_back(exp);
  endtask

  task automatic wait_rise(input int start);
    int n = 0;
    while (rise_count == start && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("rise_seen", 32'(rise_count != start), 1);
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    fall_cyc = cyc;
    chk("went_idle", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, w, fc, rc;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_sd_addr", 32'(sd_addr), 0);
    chk("rst_sd_din", 32'(sd_din), 0);
    chk("rst_sd_word", 32'(sd_word), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single byte read after reset: 0x01 ^ 0x5A = 0x5B, duplicated on both lanes.
    burst_start = rise_count; gap_exact = 1'b1;
    rc = rise_count;
    push(1'b0, 1'b0, 24'h000101, 16'h0000, 16'h5B5B, acc, w);
    wait_rise(rc);
    chk("rd_issue_latency", 32'(last_rise - acc), 2);
    wait_idle(50, fc);
    chk("sd_addr_hold", 32'(sd_addr), 32'h000101);

    // Four back-to-back word writes.
    burst_start = rise_count;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 1'b1, 24'(24'h000010 + 2 * i), 16'(16'hA001 + i), 16'h0000, acc, w);
      chk("ready_held", 32'(w), 0);
    end
    wait_idle(100, fc);
    chk("busy_fall", 32'(fc - last_rise), CYCLE - 2);

    // Six pushes into a 4-deep queue, mixed reads and writes in strict order.
    burst_start = rise_count;
    push(1'b1, 1'b0, 24'h000300, 16'h00AB, 16'h0000, acc1, w);
    push(1'b1, 1'b0, 24'h000301, 16'h00CD, 16'h0000, acc, w);
    push(1'b0, 1'b1, 24'h000300, 16'h0000, 16'hCDAB, acc, w);
    push(1'b1, 1'b1, 24'h000302, 16'h5566, 16'h0000, acc, w);
    push(1'b0, 1'b0, 24'h000303, 16'h0000, 16'h5555, acc, w);
    chk("full_ready_low", 32'(req_ready), 0);
    push(1'b0, 1'b0, 24'h000302, 16'h0000, 16'h6666, acc, w);
    chk("full_accept_cyc", 32'(acc - acc1), 12);
    wait_idle(200, fc);

    // Word write then word read of the same address.
    burst_start = rise_count;
    push(1'b1, 1'b1, 24'h000200, 16'h1234, 16'h0000, acc, w);
    push(1'b0, 1'b1, 24'h000200, 16'h0000, 16'h1234, acc, w);
    wait_idle(100, fc);

    // Read immediately followed by writes: pacing across direction changes.
    burst_start = rise_count;
    push(1'b0, 1'b0, 24'h000044, 16'h0000, 16'h1E1E, acc, w);
    push(1'b1, 1'b0, 24'h000045, 16'h0077, 16'h0000, acc, w);
    push(1'b0, 1'b1, 24'h000044, 16'h0000, 16'h771E, acc, w);
    wait_idle(100, fc);

    // Reset while a read strobe is high: strobe drops at once, response discarded.
    burst_start = rise_count;
    rc = rise_count;
    push(1'b0, 1'b0, 24'h000050, 16'h0000, 16'h0A0A, acc, w);
    wait_rise(rc);
    #2;
    chk("strobe_before_reset", 32'(sd_rd), 1);
    reset_n = 1'b0;
    #1;
    chk("reset_sd_rd_async", 32'(sd_rd), 0);
    chk("reset_sd_wr_async", 32'(sd_wr), 0);
    exp_rsp.delete();
    exp_iss.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(req_ready), 1);
    chk("post_reset_busy", 32'(busy), 0);
    repeat (15) @(negedge clk);

    // Block recovers after reset: 0x60 ^ 0x5A = 0x3A.
    burst_start = rise_count;
    rc = rise_count;
    push(1'b0, 1'b0, 24'h000060, 16'h0000, 16'h3A3A, acc, w);
    wait_rise(rc);
    chk("post_reset_latency", 32'(last_rise - acc), 2);
    wait_idle(50, fc);
    repeat (2) @(negedge clk);

    chk("iss_queue_drained", 32'(exp_iss.size()), 0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
